// File: rtl/spi_offload_core.sv
// spi_offload_core: instruction-driven SPI offload engine with an internal register bank.
// Streams {op, R[rs_a], R[rs_b]} to an external SPI ALU slave, receives the result frame
// and writes it back to R[rd].
// Optional feature macro: SPI_RX_PARITY_EN (adds a trailing even-parity bit to the RX frame;
// a parity mismatch suppresses writeback and pulses err instead of done).
module spi_offload_core #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int OP_W       = 2,
   parameter int SCLK_DIV   = 4
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           instr_valid,
   output logic                           instr_ready,
   input  logic [OP_W+3*REG_ADDR_W-1:0]   instr,
   input  logic [REG_ADDR_W-1:0]          dbg_addr,
   output logic [DATA_W-1:0]              dbg_data,
   output logic                           done,
   output logic                           err,
   output logic                           spi_sclk,
   output logic                           spi_nss,
   output logic                           spi_mosi,
   input  logic                           spi_miso
);

   localparam int N_TX = OP_W + 2*DATA_W;
`ifdef SPI_RX_PARITY_EN
   localparam int N_RX = DATA_W + 1;
`else
   localparam int N_RX = DATA_W;
`endif
   localparam int unsigned N_WORDS = 2**REG_ADDR_W;
   localparam int BIT_W = $clog2(N_TX + 1);
   localparam int PH_W  = $clog2(2*SCLK_DIV);

   localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(2*SCLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH  = PH_W'(SCLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_RISE  = PH_W'(SCLK_DIV);
   localparam logic [BIT_W-1:0] TX_LAST  = BIT_W'(N_TX - 1);
   localparam logic [BIT_W-1:0] RX_LAST  = BIT_W'(N_RX - 1);

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      TX,
      GAP,
      RX,
      WB
   } state_t;

   state_t                  state;
   logic [PH_W-1:0]         phase;
   logic [BIT_W-1:0]        bit_cnt;
   logic [OP_W-1:0]         op_q;
   logic [REG_ADDR_W-1:0]   rs_a_q;
   logic [REG_ADDR_W-1:0]   rs_b_q;
   logic [REG_ADDR_W-1:0]   rd_q;
   logic [N_TX-1:0]         tx_shift;
   logic [N_RX-1:0]         rx_shift;
   logic [DATA_W-1:0]       bank [N_WORDS];

   logic [N_TX-1:0]         load_frame;
   logic [DATA_W-1:0]       result;
`ifdef SPI_RX_PARITY_EN
   logic                    parity_ok;
`endif

   // Frame assembly from the bank and result extraction from the received word
   always_comb begin
      load_frame = {op_q, bank[rs_a_q], bank[rs_b_q]};
`ifdef SPI_RX_PARITY_EN
      result    = rx_shift[N_RX-1:1];
      // Even parity: data bits XOR parity bit must be zero
      parity_ok = ~(^rx_shift);
`else
      result    = rx_shift;
`endif
   end

   assign dbg_data = bank[dbg_addr];

   // Main sequencer: handshake, frame shifting, SCLK generation and writeback
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         phase       <= '0;
         bit_cnt     <= '0;
         op_q        <= '0;
         rs_a_q      <= '0;
         rs_b_q      <= '0;
         rd_q        <= '0;
         tx_shift    <= '0;
         rx_shift    <= '0;
         bank        <= '{default: '0};
         instr_ready <= 1'b1;
         done        <= 1'b0;
         err         <= 1'b0;
         spi_sclk    <= 1'b0;
         spi_nss     <= 1'b1;
         spi_mosi    <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (instr_valid && instr_ready) begin
                  op_q        <= instr[OP_W+3*REG_ADDR_W-1 -: OP_W];
                  rs_a_q      <= instr[3*REG_ADDR_W-1 -: REG_ADDR_W];
                  rs_b_q      <= instr[2*REG_ADDR_W-1 -: REG_ADDR_W];
                  rd_q        <= instr[REG_ADDR_W-1:0];
                  instr_ready <= 1'b0;
                  state       <= LOAD;
               end
            end
            LOAD: begin
               // Operands snapshot here, so rd aliasing a source is harmless
               tx_shift <= load_frame;
               spi_mosi <= load_frame[N_TX-1];
               spi_nss  <= 1'b0;
               spi_sclk <= 1'b0;
               phase    <= '0;
               bit_cnt  <= '0;
               state    <= TX;
            end
            TX: begin
               if (phase == PH_LAST) begin
                  phase    <= '0;
                  spi_sclk <= 1'b0;
                  if (bit_cnt == TX_LAST) begin
                     spi_nss  <= 1'b1;
                     spi_mosi <= 1'b0;
                     state    <= GAP;
                  end else begin
                     bit_cnt  <= bit_cnt + 1'b1;
                     tx_shift <= tx_shift << 1;
                     spi_mosi <= tx_shift[N_TX-2];
                  end
               end else begin
                  phase <= phase + 1'b1;
                  if (phase == PH_HIGH) spi_sclk <= 1'b1;
               end
            end
            GAP: begin
               if (phase == PH_LAST) begin
                  phase   <= '0;
                  bit_cnt <= '0;
                  spi_nss <= 1'b0;
                  state   <= RX;
               end else begin
                  phase <= phase + 1'b1;
               end
            end
            RX: begin
               // Sample on the cycle where sclk is first seen high
               if (phase == PH_RISE) rx_shift <= {rx_shift[N_RX-2:0], spi_miso};
               if (phase == PH_LAST) begin
                  phase    <= '0;
                  spi_sclk <= 1'b0;
                  if (bit_cnt == RX_LAST) begin
                     spi_nss <= 1'b1;
                     state   <= WB;
                  end else begin
                     bit_cnt <= bit_cnt + 1'b1;
                  end
               end else begin
                  phase <= phase + 1'b1;
                  if (phase == PH_HIGH) spi_sclk <= 1'b1;
               end
            end
            WB: begin
`ifdef SPI_RX_PARITY_EN
               if (parity_ok) begin
                  bank[rd_q] <= result;
                  done       <= 1'b1;
               end else begin
                  err <= 1'b1;
               end
`else
               bank[rd_q] <= result;
               done       <= 1'b1;
`endif
               instr_ready <= 1'b1;
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
